// File: rtl/fmc_div_counter_pkg.sv
// Shared constants and FSM state type for the N/M frame divider.
package fmc_pkg;

   localparam int unsigned N_W_DEF = 3;
   localparam int unsigned M_W_DEF = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } fmc_state_e;

endpackage

// File: rtl/fmc_div_counter_mod_counter.sv
// Modulo (term+1) counter stage with wrap strobe and toggle output.
module fmc_mod_counter
   import fmc_pkg::*;
#(
   parameter int unsigned W = N_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         step,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         tog,
   output logic         wrap
);

   logic [W-1:0] count_q, count_d;
   logic         tog_q, tog_d;

   assign wrap  = step && (count_q == term);
   assign count = count_q;
   assign tog   = tog_q;

   always_comb begin
      count_d = count_q;
      tog_d   = tog_q;
      if (clr) begin
         count_d = '0;
         tog_d   = 1'b0;
      end else if (wrap) begin
         count_d = '0;
         tog_d   = ~tog_q;
      end else if (step) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         tog_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tog_q   <= tog_d;
      end
   end

endmodule

// File: rtl/fmc_div_counter.sv
// Two-stage N/M frame divider with IDLE/LOAD/RUN control.
// Optional frame pulse counter enabled by macro FMC_FRAME_CNT_EN.
module fmc_div_counter
   import fmc_pkg::*;
#(
   parameter int unsigned N_W = N_W_DEF,
   parameter int unsigned M_W = M_W_DEF
) (
   input  logic           clk_out,
   input  logic           rst,
   input  logic           en,
   input  logic [N_W-1:0] N,
   input  logic [M_W-1:0] M,
   output logic [N_W-1:0] N_counter,
   output logic [M_W-1:0] M_counter,
   output logic           DIV_N,
   output logic           DIV_M,
   output logic           busy,
`ifdef FMC_FRAME_CNT_EN
   output logic           frame_done,
   output logic [7:0]     frame_cnt
`else
   output logic           frame_done
`endif
);

   fmc_state_e     state_q, state_d;
   logic [N_W-1:0] n_s_q, n_s_d;
   logic [M_W-1:0] m_s_q, m_s_d;
   logic           frame_done_q, frame_done_d;

   logic run;
   logic n_wrap;
   logic m_wrap;
   logic stage_clr;

   assign run = (state_q == RUN);
   // Stages are held clear outside RUN; the stop boundary clears the toggles on IDLE entry.
   assign stage_clr = !run || (m_wrap && !en);

   fmc_mod_counter #(.W(N_W)) u_n_stage (
      .clk   (clk_out),
      .rst   (rst),
      .clr   (stage_clr),
      .step  (run),
      .term  (n_s_q),
      .count (N_counter),
      .tog   (DIV_N),
      .wrap  (n_wrap)
   );

   fmc_mod_counter #(.W(M_W)) u_m_stage (
      .clk   (clk_out),
      .rst   (rst),
      .clr   (stage_clr),
      .step  (n_wrap),
      .term  (m_s_q),
      .count (M_counter),
      .tog   (DIV_M),
      .wrap  (m_wrap)
   );

   always_comb begin
      state_d      = state_q;
      n_s_d        = n_s_q;
      m_s_d        = m_s_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) state_d = LOAD;
         end
         LOAD: begin
            n_s_d   = N;
            m_s_d   = M;
            state_d = RUN;
         end
         RUN: begin
            if (m_wrap) begin
               frame_done_d = 1'b1;
               if (en) begin
                  n_s_d = N;
                  m_s_d = M;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_out) begin
      if (rst) begin
         state_q      <= IDLE;
         n_s_q        <= '0;
         m_s_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_s_q        <= n_s_d;
         m_s_q        <= m_s_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign busy       = (state_q == LOAD) || (state_q == RUN);
   assign frame_done = frame_done_q;

`ifdef FMC_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_done_q && (frame_cnt_q != 8'hFF)) frame_cnt_d = frame_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_out) begin
      if (rst) frame_cnt_q <= '0;
      else     frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`else
`endif

endmodule

// File: doc/fmc_div_counter.md
FMC_DIV_COUNTER -- requirements
Module: fmc_div_counter

Interface
REQ-001 Parameter: N_W, default 3, width of N and N_counter.
REQ-002 Parameter: M_W, default 2, width of M and M_counter.
REQ-003 clk_out  input  1  DLL output clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  run request; 1 = count, 0 = stop at next frame boundary.
REQ-006 N  input  N_W  N terminal count; divide-by-N is (N+1) cycles.
REQ-007 M  input  M_W  M terminal count; (M+1) N-periods per frame.
REQ-008 N_counter  output  N_W  current N count, registered.
REQ-009 M_counter  output  M_W  current M count, registered.
REQ-010 DIV_N  output  1  toggles at each N wrap, registered.
REQ-011 DIV_M  output  1  toggles at each M wrap, registered.
REQ-012 busy  output  1  high while in LOAD or RUN.
REQ-013 frame_done  output  1  one-cycle pulse, cycle after a frame boundary.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, RUN; reset state IDLE.
REQ-015 IDLE: counters, DIV_N, DIV_M held 0; en=1 -> LOAD next cycle.
REQ-016 LOAD: exactly one cycle; N_s<=N, M_s<=M (shadow registers); -> RUN.
REQ-017 RUN, N_counter!=N_s: N_counter SHALL increment by 1; nothing else changes.
REQ-018 RUN, N_counter==N_s: N_counter<=0, DIV_N<=~DIV_N, and M step SHALL occur.
REQ-019 M step, M_counter!=M_s: M_counter increments; M_counter==M_s: M_counter<=0, DIV_M<=~DIV_M (frame boundary).
REQ-020 Frame length SHALL be (N_s+1)*(M_s+1) cycles; N_s=0 SHALL give an N wrap every cycle, M_s=0 an M wrap every N wrap.
REQ-021 At frame boundary with en=1: N_s, M_s SHALL reload from N, M; stay RUN; no dead cycle.
REQ-022 At frame boundary with en=0: -> IDLE; DIV_N, DIV_M cleared on entry.
REQ-023 Changes of N or M mid-frame SHALL NOT affect counting until the next frame boundary.
REQ-024 en deasserted mid-frame SHALL NOT truncate the frame.
REQ-025 frame_done SHALL pulse high 1 cycle after each frame boundary, including the final one before IDLE.
REQ-026 busy SHALL be combinational from state: 1 in LOAD and RUN.
REQ-027 Counters SHALL never exceed their shadow terminal count; no overflow past 2^W-1.

Reset
REQ-028 rst=1 at any clk_out edge SHALL force IDLE; N_counter=0, M_counter=0, DIV_N=0, DIV_M=0, frame_done=0, N_s=0, M_s=0, in that same edge, overriding all other events including mid-frame.
REQ-029 After rst release with en=1, LOAD SHALL occur on the first edge, RUN on the second.

Configuration
REQ-030 Macro FMC_FRAME_CNT_EN defined: 8-bit output frame_cnt SHALL count frame_done pulses, saturating at 255, cleared by rst only.
REQ-031 FMC_FRAME_CNT_EN undefined: port frame_cnt and its register SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package fmc_pkg SHALL hold N_W/M_W default constants and the state enum (IDLE, LOAD, RUN).
REQ-033 Sub-module fmc_mod_counter (count, terminal compare, wrap, toggle output, step enable) SHALL be instantiated twice: N stage and M stage, M stage stepped by N wrap.

Verification
REQ-034 rst, then en=1, N=3, M=2 -> LOAD at edge 1; DIV_N toggles every 4 RUN cycles; DIV_M toggles and frame_done pulses after every 12 RUN cycles.
REQ-035 N=0, M=0, en=1 -> N_counter=0 always, DIV_N and DIV_M toggle every RUN cycle, frame_done high every cycle after the first frame.
REQ-036 RUN with N=3, M=2, change to N=1, M=1 at cycle 5 -> first frame still 12 cycles, next frames 4 cycles.
REQ-037 en dropped at RUN cycle 3 of 12-cycle frame -> frame completes, frame_done one pulse, IDLE with DIV_N=DIV_M=0, busy=0.
REQ-038 rst asserted at RUN cycle 7 -> next edge all outputs 0, IDLE; with FMC_FRAME_CNT_EN, frame_cnt=0 and saturates at 255 after 300 frames.
